// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritises memory wait, EX redirect and
// load-use hazards, tracks memory-wait duration and keeps stall/redirect counters.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int WAIT_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_sel_redirect,
    output logic        if_id_valid,
    output logic        if_id_flush,
    output logic        id_ex_valid,
    output logic        id_ex_flush,
    output logic        ex_mem_valid,
    output logic        ex_mem_flush,
    output logic        mem_wb_valid,
    output logic        mem_wb_flush,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HUNG     = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                mem_stall;
    logic                load_use;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    assign state_dbg = state;

    // Controls are purely combinational; everything is forced low while reset is held.
    always_comb begin
        pc_write        = 1'b0;
        pc_sel_redirect = 1'b0;
        if_id_valid     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_valid     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_valid    = 1'b0;
        ex_mem_flush    = 1'b0;
        mem_wb_valid    = 1'b0;
        mem_wb_flush    = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                // Upstream frozen; a bubble drains into WB. A pending redirect waits in EX.
                mem_wb_valid = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_redirect) begin
                pc_write        = 1'b1;
                pc_sel_redirect = 1'b1;
                if_id_valid     = 1'b1;
                if_id_flush     = 1'b1;
                id_ex_valid     = 1'b1;
                id_ex_flush     = 1'b1;
                ex_mem_valid    = 1'b1;
                mem_wb_valid    = 1'b1;
            end else if (load_use) begin
                id_ex_valid  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_valid = 1'b1;
                mem_wb_valid = 1'b1;
            end else begin
                pc_write     = 1'b1;
                if_id_valid  = 1'b1;
                id_ex_valid  = 1'b1;
                ex_mem_valid = 1'b1;
                mem_wb_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (mem_stall) state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_ready)                             state_next = RUN;
                else if (wait_cnt == WAIT_W'(TIMEOUT))     state_next = HUNG;
            end
            HUNG: begin
                if (mem_ready) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            wait_cnt       <= '0;
            mem_timeout    <= 1'b0;
            stall_cycles   <= 32'd0;
            redirect_count <= 32'd0;
        end else begin
            state <= state_next;
            if (state != MEM_WAIT && state_next == MEM_WAIT)
                wait_cnt <= '0;
            else if (state == MEM_WAIT && mem_stall && wait_cnt != WAIT_W'(TIMEOUT))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            // Sticky: raised on entry to HUNG so it is visible in the first HUNG cycle.
            if (state_next == HUNG)
                mem_timeout <= 1'b1;
            if (!pc_write)
                stall_cycles <= stall_cycles + 32'd1;
            if (pc_sel_redirect)
                redirect_count <= redirect_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops and compares every cycle that carries an expectation.
module tb_pipe_hazard_ctrl;

    localparam int EW = 77;

    // Control vector order: pc_write, pc_sel, if_id v/f, id_ex v/f, ex_mem v/f, mem_wb v/f
    localparam logic [9:0] C_NORM = 10'b1_0_1_0_1_0_1_0_1_0;
    localparam logic [9:0] C_LU   = 10'b0_0_0_0_1_1_1_0_1_0;
    localparam logic [9:0] C_RED  = 10'b1_1_1_1_1_1_1_0_1_0;
    localparam logic [9:0] C_MS   = 10'b0_0_0_0_0_0_0_0_1_1;
    localparam logic [9:0] C_ZERO = 10'b0;
    localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_HUNG = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic        pc_write, pc_sel_redirect, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush;
    logic        ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush, mem_timeout;
    logic [31:0] stall_cycles, redirect_count;
    logic [1:0]  state_dbg;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            failures = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(4), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_sel_redirect(pc_sel_redirect),
        .if_id_valid(if_id_valid), .if_id_flush(if_id_flush),
        .id_ex_valid(id_ex_valid), .id_ex_flush(id_ex_flush),
        .ex_mem_valid(ex_mem_valid), .ex_mem_flush(ex_mem_flush),
        .mem_wb_valid(mem_wb_valid), .mem_wb_flush(mem_wb_flush),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
        .redirect_count(redirect_count), .state_dbg(state_dbg)
    );

    // Driver: one call = one clock cycle of inputs, optionally with an expectation.
    task automatic step(input string nm, input logic rst,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic red,
                        input logic mq, input logic my,
                        input logic chk, input logic [9:0] ctrl, input logic tmo,
                        input logic [31:0] st, input logic [31:0] rc, input logic [1:0] sd);
        @(posedge clk);
        #1;
        reset = rst; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        ex_rd = rd; ex_mem_read = mr; ex_redirect = red; mem_req = mq; mem_ready = my;
        if (chk) begin
            exp_q.push_back({ctrl, tmo, st, rc, sd});
            name_q.push_back(nm);
        end
    endtask

    task automatic idle(input string nm, input logic [31:0] st, input logic [31:0] rc,
                        input logic tmo, input logic [1:0] sd);
        step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NORM, tmo, st, rc, sd);
    endtask

    task automatic mstall(input string nm, input logic red, input logic [31:0] st,
                          input logic [31:0] rc, input logic tmo, input logic [1:0] sd);
        step(nm, 0, 0, 0, 0, 0, 0, 0, red, 1, 0, 1, C_MS, tmo, st, rc, sd);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            logic [EW-1:0] a;
            string         nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {pc_write, pc_sel_redirect, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush,
                  ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush, mem_timeout,
                  stall_cycles, redirect_count, state_dbg};
            checks = checks + 1;
            if (a !== e) begin
                failures = failures + 1;
                $display("FAIL %s: ctrl=%b tmo=%b stall=%0d redir=%0d state=%0d, expected ctrl=%b tmo=%b stall=%0d redir=%0d state=%0d",
                         nm, a[76:67], a[66], a[65:34], a[33:2], a[1:0],
                         e[76:67], e[66], e[65:34], e[33:2], e[1:0]);
            end
        end
    end

    initial begin
        reset = 1'b1; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd = 0; ex_mem_read = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
        step("reset_first", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO, 0, 0, 0, S_RUN);
        step("reset_held", 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, C_ZERO, 0, 0, 0, S_RUN);
        idle("idle_after_reset", 0, 0, 0, S_RUN);
        step("load_use_rs2", 0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 1, C_LU, 0, 0, 0, S_RUN);
        idle("after_load_use", 1, 0, 0, S_RUN);
        step("x0_dest", 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, C_NORM, 0, 1, 0, S_RUN);
        step("unused_source", 0, 7, 0, 3, 1, 7, 1, 0, 0, 0, 1, C_NORM, 0, 1, 0, S_RUN);
        step("load_use_rs1", 0, 9, 1, 0, 0, 9, 1, 0, 0, 0, 1, C_LU, 0, 1, 0, S_RUN);
        step("redirect_over_lu", 0, 9, 1, 0, 0, 9, 1, 1, 0, 0, 1, C_RED, 0, 2, 0, S_RUN);
        idle("after_redirect", 2, 1, 0, S_RUN);
        mstall("mw_redir_1", 1, 2, 1, 0, S_RUN);
        mstall("mw_redir_2", 1, 3, 1, 0, S_MW);
        mstall("mw_redir_3", 1, 4, 1, 0, S_MW);
        step("mw_release_redir", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, C_RED, 0, 5, 1, S_MW);
        idle("after_release", 5, 2, 0, S_RUN);
        step("ready_without_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM, 0, 5, 2, S_RUN);
        // Ten stall cycles with TIMEOUT=4: timeout visible from the 7th cycle on
        for (int k = 0; k < 10; k++) begin
            mstall("timeout_stall", 0, 32'(5 + k), 2, (k >= 6) ? 1'b1 : 1'b0,
                   (k == 0) ? S_RUN : ((k >= 6) ? S_HUNG : S_MW));
        end
        step("hung_release", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_NORM, 1, 15, 2, S_HUNG);
        idle("sticky_timeout", 15, 2, 1, S_RUN);
        for (int k = 0; k < 7; k++) begin
            mstall("rehang_stall", 0, 32'(15 + k), 2, 1'b1,
                   (k == 0) ? S_RUN : ((k == 6) ? S_HUNG : S_MW));
        end
        step("reset_in_hung", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_ZERO, 1, 22, 2, S_HUNG);
        idle("after_reset_hung", 0, 0, 0, S_RUN);
        idle("idle_final", 0, 0, 0, S_RUN);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage core. Generates the `valid` (hold/enable) and `flush` (bubble) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It resolves three hazard sources with fixed priority:

1. Data-memory wait.
2. EX-stage control-flow redirect.
3. Load-use dependency.

It also tracks memory-wait duration and keeps performance counters.

## Interface
Parameters:
- `TIMEOUT`, default 255: MEM_WAIT cycles before `mem_timeout` is raised.
- `WAIT_W`, default 8: width of the wait counter; must satisfy `TIMEOUT < 2^WAIT_W`.

Ports (clock and reset first):
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_rs1`  in  5  source register 1 of the instruction in ID.
- `id_rs2`  in  5  source register 2 of the instruction in ID.
- `id_rs1_used`  in  1  ID instruction reads rs1.
- `id_rs2_used`  in  1  ID instruction reads rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  EX instruction is a load (the ID/EX `mem_read` output).
- `ex_redirect`  in  1  EX resolved a taken branch or jump.
- `mem_req`  in  1  MEM stage holds a load/store.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC register enable.
- `pc_sel_redirect`  out  1  PC takes the EX target instead of PC+4.
- `if_id_valid`  out  1  IF/ID register enable.
- `if_id_flush`  out  1  IF/ID register flush.
- `id_ex_valid`  out  1  ID/EX register enable.
- `id_ex_flush`  out  1  ID/EX register flush.
- `ex_mem_valid`  out  1  EX/MEM register enable.
- `ex_mem_flush`  out  1  EX/MEM register flush.
- `mem_wb_valid`  out  1  MEM/WB register enable.
- `mem_wb_flush`  out  1  MEM/WB register flush.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cycles`  out  32  count of cycles with `pc_write=0`.
- `redirect_count`  out  32  count of applied redirects.

## Operation
- **Derived signals:**
  - `mem_stall = mem_req & ~mem_ready`.
  - `load_use = ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- **Control outputs** are combinational from the inputs, and are valid in the same cycle. Priority is highest first:
  - **mem_stall:**
    - `pc_write`, `if_id_valid`, `id_ex_valid` and `ex_mem_valid` are 0.
    - All flushes are 0, except `mem_wb_flush=1` with `mem_wb_valid=1` (bubble into WB).
    - `ex_redirect` is ignored. EX is frozen, so the redirect is re-presented later.
  - **ex_redirect:**
    - `pc_write=1`, `pc_sel_redirect=1`.
    - `if_id_flush=1`, `id_ex_flush=1`.
    - All `valid` outputs are 1.
    - `load_use` is ignored.
  - **load_use:**
    - `pc_write=0`, `if_id_valid=0`.
    - `id_ex_flush=1` (bubble).
    - `ex_mem_valid=1`, `mem_wb_valid=1`.
  - **Otherwise:** all `valid` outputs are 1, all flushes are 0, `pc_write=1`, `pc_sel_redirect=0`.
- Flush is only asserted together with `valid=1` on the same register; the register treats flush as dominant.
- **FSM states:** RUN, MEM_WAIT, HUNG.
  - From RUN: go to MEM_WAIT if `mem_stall`; otherwise stay in RUN.
  - In MEM_WAIT:
    - If `mem_ready`, return to RUN. The release cycle applies the normal priority rules.
    - Else if `wait_cnt == TIMEOUT`, go to HUNG.
    - Otherwise stay.
  - In HUNG: `mem_timeout=1`. Outputs still follow the rules above. Return to RUN on `mem_ready`; `mem_timeout` stays set.
- **Wait counter (`wait_cnt`):**
  - Cleared to 0 on entry to MEM_WAIT.
  - Increments each MEM_WAIT cycle while `mem_stall`.
  - Saturates at `TIMEOUT`.
- **`mem_timeout`** is cleared only by reset.
- **Counters:**
  - `stall_cycles` increments on every cycle with `pc_write=0`.
  - `redirect_count` increments on every cycle with `pc_sel_redirect=1`.
  - Both wrap modulo 2^32.

## Timing
- **During reset:**
  - All `valid` outputs, all `flush` outputs, `pc_write` and `pc_sel_redirect` are 0.
  - Registered values take effect at the next edge: state=RUN, `wait_cnt=0`, `mem_timeout=0`, both counters 0.
- **Reset in the middle of MEM_WAIT or HUNG** returns to RUN at the next edge, with counters and flag cleared.
- **Latency:**
  - Control outputs: 0 cycles (combinational).
  - `mem_timeout` and counters: update 1 edge after the qualifying cycle.
- **Load-use** costs exactly 1 stall cycle. In the following cycle the load is in MEM, so `load_use` is 0 unless a new dependency arises.
- **Redirect** costs 2 bubbles (IF/ID and ID/EX flushed in one cycle).
- **Simultaneous `mem_ready` and `ex_redirect`** in MEM_WAIT: the redirect is applied in that same cycle.
- **`mem_ready` without `mem_req`** is ignored.

## Test plan
- **Load-use:** `ex_mem_read=1`, `ex_rd=5`, `id_rs2=5`, `id_rs2_used=1` for 1 cycle. Required: `pc_write=0`, `if_id_valid=0`, `id_ex_flush=1`; `stall_cycles` goes 0→1.
- **x0 and unused source:** `ex_rd=0` with a matching source, or a match only on an unused source. Required: no stall, all `valid=1`.
- **Redirect vs load-use:** `ex_redirect=1` together with `load_use`. Required: `pc_sel_redirect=1`, `if_id_flush=id_ex_flush=1`, `pc_write=1`; `redirect_count=1`.
- **Memory wait with pending redirect:** `mem_req=1`, `mem_ready=0` for 3 cycles with `ex_redirect=1`, then `mem_ready=1`. Required:
  - Freeze for 3 cycles with `mem_wb_flush=1`.
  - Redirect applied in the release cycle.
  - `stall_cycles=3`.
- **Timeout:** `TIMEOUT=4`, `mem_stall` held for 10 cycles. Required: `mem_timeout` rises after 6 stall cycles, and stays 1 after `mem_ready`.
- **Reset mid-wait:** assert `reset` during HUNG. Required: next edge gives RUN, `mem_timeout=0`, counters 0; during reset all control outputs are 0.
